sa_cache: RTL and testbench
===========================

// Module: sa_cache
// PURPOSE
//  Parametrised N-way set-associative data cache for the MEM stage, replacing the single-cycle direct-mapped cache.
//  Write-through, no-write-allocate, one outstanding miss, line refill over a req/ack memory port.
//  Hits complete combinationally in the MEM cycle. Misses and writes raise stall; the hazard path freezes IF..MEM while it is high.
// PARAMETERS
//  WIDTH           32  data/address width in bits (byte-addressed)
//  WAYS            2   associativity; power of two, 1..4
//  SETS            64  sets; power of two >= 2
//  WORDS_PER_LINE  4   words per line; power of two >= 1
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous active-high reset
//  read_en     in   1      MEM-stage load
//  write_en    in   1      MEM-stage store; read_en & write_en is illegal
//  addr_mode   in   3      funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr        in   WIDTH  byte address
//  write_data  in   WIDTH  store data, right-aligned
//  out         out  WIDTH  load data, extended per addr_mode
//  stall       out  1      access incomplete; hold MEM-stage inputs stable
//  mem_req     out  1      backing-memory request
//  mem_we      out  1      1 = write, 0 = read word
//  mem_addr    out  WIDTH  word-aligned address
//  mem_wdata   out  WIDTH  write data, lane-positioned
//  mem_wstrb   out  4      byte-enable strobe
//  mem_ack     in   1      one-cycle completion; rdata valid with ack
//  mem_rdata   in   WIDTH  read word
// BEHAVIOUR
//  - Address split {tag, set, word offset, byte[1:0]}. Half/word accesses ignore the low address bits (forced aligned).
//  - Reset clears all valid bits, victim pointers and FSM (IDLE). Outputs are 0 during reset and in IDLE without a hit.
//  - FSM IDLE:
//    - read hit -> out valid same cycle, stall=0.
//    - read miss -> stall=1 this cycle, go to REFILL.
//    - write (hit or miss) -> stall=1, go to WRITE.
//  - REFILL:
//    - Word counter 0..WORDS_PER_LINE-1 from the line base; mem_req=1, mem_we=0 until each ack.
//    - Each ack writes that word into the victim way. After the last ack: set valid and tag, advance the pointer, go to IDLE.
//    - The re-presented read then hits (stall=0) the next cycle. Miss latency = sum of ack waits + 1 cycle.
//  - WRITE:
//    - mem_req=1, mem_we=1, strobe/data from addr_mode and byte offset.
//    - On a write hit, the cached bytes update on the same edge the request is first issued.
//    - On ack, go to IDLE and drop stall on the following cycle. Write miss leaves the cache unchanged.
//  - stall stays high in REFILL/WRITE through and including the ack cycle.
//  - Victim selection: lowest-index invalid way; else the per-set round-robin pointer, which wraps WAYS-1 -> 0. Hits do not move the pointer.
//  - Hold contract: mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay stable while mem_req=1 && !mem_ack.
//  - Extension: bu/hu zero-extend; b/h sign-extend from bit 7/15.
//  - Reset mid-REFILL or mid-WRITE: FSM to IDLE, mem_req=0 the next cycle, the partial line is never marked valid.
//  - WAYS=1 degenerates to direct-mapped; the pointer is unused.
// TESTING
//  1. Reset, read_en addr 0x100 w, mem returns 0x11,0x22,0x33,0x44 for 0x100..0x10C (1-cycle ack).
//     -> 4 reads, stall high 5 cycles, then out=0x11. Read 0x108 -> out=0x33, stall=0, no mem_req.
//  2. After test 1, sb 0x80 to 0x101.
//     -> mem_we=1, mem_addr=0x100, mem_wstrb=0010, mem_wdata=0x00008000.
//     -> Then lbu 0x101 = 0x80, lb 0x101 = 0xFFFFFF80, lw 0x100 = 0x00008011.
//  3. WAYS=2, SETS=64, WPL=4: read 0x0000, 0x0400, 0x0800 (same set), then 0x0000.
//     -> Third fill evicts way0 (0x0000); the final read misses and refills.
//  4. Store miss to 0x2000 -> one memory write, a following read of 0x2000 misses (no allocate).
//  5. Assert rst during the second refill ack-wait -> mem_req=0 next cycle; re-reading the same address misses again.
//  6. mem_ack delayed 3 cycles per word -> request fields held constant throughout; stall deasserts exactly 1 cycle after the last ack.

Source files
------------

// File: rtl/sa_cache.sv
// sa_cache: N-way set-associative write-through data cache for the MEM stage.
// Hits return combinationally; misses refill a line, stores write through.
module sa_cache #(
  parameter int WIDTH          = 32,
  parameter int WAYS           = 2,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic             write_en,
  input  logic [2:0]       addr_mode,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] out,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int WOB  = $clog2(WORDS_PER_LINE);
  localparam int OFFW = (WOB > 0) ? WOB : 1;
  localparam int SETW = $clog2(SETS);
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAGW = WIDTH - 2 - WOB - SETW;
  localparam logic [OFFW-1:0] LAST  = OFFW'(WORDS_PER_LINE - 1);
  localparam logic [WAYW-1:0] WLAST = WAYW'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] data_q  [WAYS][SETS][WORDS_PER_LINE];
  logic [TAGW-1:0]  tag_q   [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYW-1:0]  ptr_q   [SETS];

  logic [OFFW-1:0] cnt_q;
  logic [WAYW-1:0] way_q;
  logic            wdone_q;

  logic [SETW-1:0] set_idx;
  logic [OFFW-1:0] word_idx;
  logic [TAGW-1:0] tag_in;
  logic [1:0]      boff;

  logic            hit;
  logic [WAYW-1:0] hit_way;
  logic [WAYW-1:0] vic_way;
  logic            vic_found;

  logic [WIDTH-1:0] rd_word;
  logic [7:0]       bsel;
  logic [15:0]      hsel;
  logic [WIDTH-1:0] ext;
  logic [3:0]       strb;
  logic [WIDTH-1:0] wlane;

  logic start_fill;
  logic fill_ack;
  logic fill_done;
  logic wr_upd;

  assign boff     = addr[1:0];
  assign word_idx = OFFW'((addr >> 2) & WIDTH'(WORDS_PER_LINE - 1));
  assign set_idx  = SETW'(addr >> (2 + WOB));
  assign tag_in   = TAGW'(addr >> (2 + WOB + SETW));

  // Tag match across ways and victim choice (first invalid, else pointer)
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_way   = ptr_q[set_idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_q[w][set_idx] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!valid_q[set_idx][w] && !vic_found) begin
        vic_way   = WAYW'(w);
        vic_found = 1'b1;
      end
    end
  end

  assign rd_word = data_q[hit_way][set_idx][word_idx];
  assign bsel    = 8'(rd_word >> {boff, 3'b000});
  assign hsel    = 16'(rd_word >> {boff[1], 4'b0000});

  // Load extraction and sign/zero extension
  always_comb begin
    ext = rd_word;
    case (addr_mode)
      3'b000:  ext = {{(WIDTH-8){bsel[7]}}, bsel};
      3'b001:  ext = {{(WIDTH-16){hsel[15]}}, hsel};
      3'b100:  ext = {{(WIDTH-8){1'b0}}, bsel};
      3'b101:  ext = {{(WIDTH-16){1'b0}}, hsel};
      default: ext = rd_word;
    endcase
  end

  // Store lane placement and byte strobes
  always_comb begin
    strb  = 4'b1111;
    wlane = write_data;
    case (addr_mode[1:0])
      2'b00: begin
        strb  = 4'b0001 << boff;
        wlane = WIDTH'(write_data[7:0]) << {boff, 3'b000};
      end
      2'b01: begin
        strb  = 4'b0011 << {boff[1], 1'b0};
        wlane = WIDTH'(write_data[15:0]) << {boff[1], 4'b0000};
      end
      default: begin
        strb  = 4'b1111;
        wlane = write_data;
      end
    endcase
  end

  // Next state, stall and memory-port outputs
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    out        = '0;
    start_fill = 1'b0;
    fill_ack   = 1'b0;
    fill_done  = 1'b0;
    wr_upd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_en) begin
          if (!wdone_q) begin
            stall   = 1'b1;
            wr_upd  = hit;
            state_d = WRITE;
          end
        end else if (read_en) begin
          if (hit) begin
            out = ext;
          end else begin
            stall      = 1'b1;
            start_fill = 1'b1;
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = (addr & ~WIDTH'(WORDS_PER_LINE * 4 - 1))
                 | (WIDTH'(cnt_q) << 2);
        fill_ack = mem_ack;
        if (mem_ack && cnt_q == LAST) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[WIDTH-1:2], 2'b00};
        mem_wdata = wlane;
        mem_wstrb = strb;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d    = IDLE;
      stall      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      out        = '0;
      start_fill = 1'b0;
      fill_ack   = 1'b0;
      fill_done  = 1'b0;
      wr_upd     = 1'b0;
    end
  end

  // Control state: FSM, refill counter, valid bits, victim pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
      wdone_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      wdone_q <= (state_q == WRITE) && mem_ack;
      if (start_fill) begin
        way_q                     <= vic_way;
        cnt_q                     <= '0;
        valid_q[set_idx][vic_way] <= 1'b0;
      end
      if (fill_ack) cnt_q <= cnt_q + 1'b1;
      if (fill_done) begin
        valid_q[set_idx][way_q] <= 1'b1;
        ptr_q[set_idx] <= (ptr_q[set_idx] == WLAST) ? '0
                        : ptr_q[set_idx] + 1'b1;
      end
    end
  end

  // Line storage: refill words, tags, and store-hit byte merges
  always_ff @(posedge clk) begin
    if (fill_ack) data_q[way_q][set_idx][cnt_q] <= mem_rdata;
    if (fill_done) tag_q[way_q][set_idx] <= tag_in;
    if (wr_upd) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b])
          data_q[hit_way][set_idx][word_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: directed self-checking bench for sa_cache.
// A word-array backing memory with programmable ack delay answers the cache.
module tb_sa_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic        write_en;
  logic [2:0]  addr_mode;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] out;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_arr [0:4095];
  int dly = 1;
  int wc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int hold_err = 0;
  logic [31:0] lw_addr = '0;
  logic [31:0] lw_data = '0;
  logic [3:0]  lw_strb = '0;

  logic        hp = 1'b0;
  logic        h_we = 1'b0;
  logic [31:0] h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic [3:0]  h_strb = '0;

  sa_cache dut (
    .clk        (clk),
    .rst        (rst),
    .read_en    (read_en),
    .write_en   (write_en),
    .addr_mode  (addr_mode),
    .addr       (addr),
    .write_data (write_data),
    .out        (out),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wc == dly - 1);
  assign mem_rdata = mem_arr[mem_addr[13:2]];

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Backing memory: ack after dly cycles of request, count transfers
  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      if (mem_we) begin
        mem_arr[mem_addr[13:2]] <= merge(mem_arr[mem_addr[13:2]],
                                         mem_wdata, mem_wstrb);
        wr_cnt  <= wr_cnt + 1;
        lw_addr <= mem_addr;
        lw_data <= mem_wdata;
        lw_strb <= mem_wstrb;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
    wc <= (!rst && mem_req && !mem_ack) ? wc + 1 : 0;
  end

  // Request fields must not move while a request waits for its ack
  always @(negedge clk) begin
    if (hp && !rst &&
        (mem_req !== 1'b1 || mem_we !== h_we || mem_addr !== h_addr ||
         mem_wdata !== h_wdata || mem_wstrb !== h_strb))
      hold_err = hold_err + 1;
    hp      = mem_req && !mem_ack && !rst;
    h_we    = mem_we;
    h_addr  = mem_addr;
    h_wdata = mem_wdata;
    h_strb  = mem_strb_copy();
  end

  function automatic logic [3:0] mem_strb_copy();
    return mem_wstrb;
  endfunction

  task automatic access(input bit we, input logic [2:0] mode,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stalls, output logic [31:0] o);
    bit done;
    read_en    = !we;
    write_en   = we;
    addr_mode  = mode;
    addr       = a;
    write_data = wd;
    stalls     = 0;
    o          = 'x;
    done       = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!stall) begin
        o    = out;
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    @(posedge clk);
    #1;
    read_en  = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    read_en   = 1'b1;
    addr_mode = 3'b010;
    addr      = 32'h100;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", mem_req); end
    n_cmp++; if (out !== 32'h0) begin n_bad++; $display("FAIL rst_out got %h want 0", out); end
    @(posedge clk);
    #1;
    read_en = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req got %b want 0", mem_req); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_refill();
    int st; logic [31:0] o; int r0;
    dly = 1;
    r0 = rd_cnt;
    access(1'b0, 3'b010, 32'h100, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t1_stall got %0d want 5", st); end
    n_cmp++; if (o !== 32'h11) begin n_bad++; $display("FAIL t1_out got %h want 00000011", o); end
    n_cmp++; if (rd_cnt - r0 !== 4) begin n_bad++; $display("FAIL t1_reads got %0d want 4", rd_cnt - r0); end
    r0 = rd_cnt;
    access(1'b0, 3'b010, 32'h108, 32'h0, st, o);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL t1_hit_stall got %0d want 0", st); end
    n_cmp++; if (o !== 32'h33) begin n_bad++; $display("FAIL t1_hit_out got %h want 00000033", o); end
    n_cmp++; if (rd_cnt !== r0) begin n_bad++; $display("FAIL t1_hit_reads got %0d want %0d", rd_cnt, r0); end
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] o; int w0;
    w0 = wr_cnt;
    access(1'b1, 3'b000, 32'h101, 32'h80, st, o);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL t2_stall got %0d want 2", st); end
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL t2_writes got %0d want 1", wr_cnt - w0); end
    n_cmp++; if (lw_addr !== 32'h100) begin n_bad++; $display("FAIL t2_addr got %h want 00000100", lw_addr); end
    n_cmp++; if (lw_strb !== 4'b0010) begin n_bad++; $display("FAIL t2_strb got %b want 0010", lw_strb); end
    n_cmp++; if (lw_data !== 32'h8000) begin n_bad++; $display("FAIL t2_wdata got %h want 00008000", lw_data); end
    access(1'b0, 3'b100, 32'h101, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'h80) begin n_bad++; $display("FAIL t2_lbu got %h/%0d want 00000080/0", o, st); end
    access(1'b0, 3'b000, 32'h101, 32'h0, st, o);
    n_cmp++; if (o !== 32'hFFFFFF80) begin n_bad++; $display("FAIL t2_lb got %h want ffffff80", o); end
    access(1'b0, 3'b010, 32'h100, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'h8011) begin n_bad++; $display("FAIL t2_lw got %h/%0d want 00008011/0", o, st); end
    access(1'b0, 3'b001, 32'h100, 32'h0, st, o);
    n_cmp++; if (o !== 32'hFFFF8011) begin n_bad++; $display("FAIL t2_lh got %h want ffff8011", o); end
    access(1'b0, 3'b101, 32'h101, 32'h0, st, o);
    n_cmp++; if (o !== 32'h8011) begin n_bad++; $display("FAIL t2_lhu_align got %h want 00008011", o); end
  endtask

  task automatic test_evict();
    int st; logic [31:0] o;
    access(1'b0, 3'b010, 32'h0000, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t3_fill0 got %0d want 5", st); end
    access(1'b0, 3'b010, 32'h0400, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t3_fill1 got %0d want 5", st); end
    access(1'b0, 3'b010, 32'h0800, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t3_fill2 got %0d want 5", st); end
    access(1'b0, 3'b010, 32'h0000, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t3_evicted got %0d want 5", st); end
    n_cmp++; if (o !== 32'hA5A50000) begin n_bad++; $display("FAIL t3_data got %h want a5a50000", o); end
    access(1'b0, 3'b010, 32'h0800, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'hA5A50800) begin n_bad++; $display("FAIL t3_keep got %h/%0d want a5a50800/0", o, st); end
    access(1'b0, 3'b010, 32'h0400, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t3_rr got %0d want 5", st); end
  endtask

  task automatic test_write_miss();
    int st; logic [31:0] o; int w0;
    w0 = wr_cnt;
    access(1'b1, 3'b010, 32'h2000, 32'h12345678, st, o);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL t4_stall got %0d want 2", st); end
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL t4_writes got %0d want 1", wr_cnt - w0); end
    n_cmp++; if (lw_addr !== 32'h2000 || lw_strb !== 4'hF) begin n_bad++; $display("FAIL t4_req got %h/%b want 00002000/1111", lw_addr, lw_strb); end
    access(1'b0, 3'b010, 32'h2000, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t4_noalloc got %0d want 5", st); end
    n_cmp++; if (o !== 32'h12345678) begin n_bad++; $display("FAIL t4_data got %h want 12345678", o); end
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] o; int r0; bit found;
    dly = 3;
    r0 = rd_cnt;
    found = 1'b0;
    read_en   = 1'b1;
    addr_mode = 3'b010;
    addr      = 32'h300;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rd_cnt == r0 + 1 && mem_req && !mem_ack) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL t5_wait got 0 want 1"); end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    read_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL t5_req_rst got %b want 0", mem_req); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL t5_idle got %b/%b want 0/0", mem_req, stall); end
    @(posedge clk);
    #1;
    dly = 1;
    access(1'b0, 3'b010, 32'h300, 32'h0, st, o);
    n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL t5_remiss got %0d want 5", st); end
    n_cmp++; if (o !== 32'hA5A50300) begin n_bad++; $display("FAIL t5_data got %h want a5a50300", o); end
  endtask

  task automatic test_slow_ack();
    int st; logic [31:0] o; int h0;
    dly = 3;
    h0 = hold_err;
    access(1'b0, 3'b010, 32'h500, 32'h0, st, o);
    n_cmp++; if (st !== 13) begin n_bad++; $display("FAIL t6_stall got %0d want 13", st); end
    n_cmp++; if (o !== 32'hA5A50500) begin n_bad++; $display("FAIL t6_data got %h want a5a50500", o); end
    access(1'b1, 3'b010, 32'h504, 32'hCAFEF00D, st, o);
    n_cmp++; if (st !== 4) begin n_bad++; $display("FAIL t6_wstall got %0d want 4", st); end
    dly = 1;
    access(1'b0, 3'b010, 32'h504, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'hCAFEF00D) begin n_bad++; $display("FAIL t6_hit got %h/%0d want cafef00d/0", o, st); end
    n_cmp++; if (hold_err !== h0) begin n_bad++; $display("FAIL t6_hold got %0d want %0d", hold_err, h0); end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] o;
    access(1'b0, 3'b010, 32'h500, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'hA5A50500) begin n_bad++; $display("FAIL b2b_0 got %h/%0d want a5a50500/0", o, st); end
    access(1'b0, 3'b000, 32'h507, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'hFFFFFFCA) begin n_bad++; $display("FAIL b2b_1 got %h/%0d want ffffffca/0", o, st); end
    access(1'b0, 3'b101, 32'h506, 32'h0, st, o);
    n_cmp++; if (st !== 0 || o !== 32'h0000CAFE) begin n_bad++; $display("FAIL b2b_2 got %h/%0d want 0000cafe/0", o, st); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = 32'hA5A50000 ^ (i << 2);
    mem_arr[32'h100 >> 2] = 32'h11;
    mem_arr[32'h104 >> 2] = 32'h22;
    mem_arr[32'h108 >> 2] = 32'h33;
    mem_arr[32'h10C >> 2] = 32'h44;
    rst        = 1'b1;
    read_en    = 1'b0;
    write_en   = 1'b0;
    addr_mode  = 3'b010;
    addr       = '0;
    write_data = '0;
    test_reset();
    test_refill();
    test_store_hit();
    test_evict();
    test_write_miss();
    test_reset_mid();
    test_slow_ack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
